// File: rtl/dreimann_dice_roller.sv
// rtl/dreimann_dice_roller.sv - two-dice roller: synchronized/debounced button, free-running LFSR, roll FSM
// Optional feature macro: DREIMANN_DICE_ANIM_EN (dice tumble on every animation step during ROLL)

module dreimann_dice_roller #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int ANIM_STEPS      = 8,
   parameter int ANIM_DIV        = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       roll_i,
   output logic [2:0] dice_a_o,
   output logic [2:0] dice_b_o,
   output logic       valid_o,
   output logic       busy_o,
   output logic       pasch_o,
   output logic       three_o
);

   typedef enum logic [1:0] {IDLE, ROLL, DONE} state_t;

   localparam logic [7:0]  DB_LAST    = 8'(DEBOUNCE_CYCLES - 1);
   localparam logic [7:0]  DIV_LAST   = 8'(ANIM_DIV - 1);
   localparam logic [7:0]  STEP_LAST  = 8'(ANIM_STEPS - 1);
   localparam logic [15:0] LFSR_SEED  = 16'hACE1;
   localparam logic [15:0] LFSR_TAPS  = 16'hB400;

   // 3-bit value mod 6, plus one: 0..5 -> 1..6, 6 -> 1, 7 -> 2
   function automatic logic [2:0] face(input logic [2:0] v);
      return (v >= 3'd6) ? v - 3'd5 : v + 3'd1;
   endfunction

   logic        sync1, sync2;
   logic        db_level, db_prev, rise_q;
   logic [7:0]  db_cnt;
   logic [15:0] lfsr;
   logic [7:0]  div_cnt, step_cnt;
   state_t      state_q, state_d;
   logic [2:0]  face_a, face_b;
   logic        tick, last_step, dice_upd;

   assign face_a    = face(lfsr[2:0]);
   assign face_b    = face(lfsr[10:8]);
   assign tick      = (div_cnt == DIV_LAST);
   assign last_step = tick && (step_cnt == STEP_LAST);

`ifdef DREIMANN_DICE_ANIM_EN
   assign dice_upd = (state_q == ROLL) && tick;
`else
   assign dice_upd = (state_q == ROLL) && last_step;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1    <= 1'b0;
         sync2    <= 1'b0;
         db_level <= 1'b0;
         db_prev  <= 1'b0;
         rise_q   <= 1'b0;
         db_cnt   <= 8'd0;
         lfsr     <= LFSR_SEED;
      end else begin
         sync1    <= roll_i;
         sync2    <= sync1;
         db_prev  <= db_level;
         rise_q   <= db_level & ~db_prev;
         lfsr     <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);
         // any sample agreeing with the current level restarts the stability count
         if (sync2 != db_level) begin
            if (db_cnt == DB_LAST) begin
               db_level <= sync2;
               db_cnt   <= 8'd0;
            end else begin
               db_cnt <= db_cnt + 8'd1;
            end
         end else begin
            db_cnt <= 8'd0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // edges arriving outside IDLE are dropped, never queued
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (rise_q) state_d = ROLL;
         ROLL:    if (last_step) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         div_cnt  <= 8'd0;
         step_cnt <= 8'd0;
         dice_a_o <= 3'd1;
         dice_b_o <= 3'd1;
         pasch_o  <= 1'b0;
         three_o  <= 1'b0;
      end else begin
         if (state_q == ROLL) begin
            if (tick) begin
               div_cnt  <= 8'd0;
               step_cnt <= step_cnt + 8'd1;
            end else begin
               div_cnt <= div_cnt + 8'd1;
            end
         end else begin
            div_cnt  <= 8'd0;
            step_cnt <= 8'd0;
         end
         if (dice_upd) begin
            dice_a_o <= face_a;
            dice_b_o <= face_b;
         end
         if ((state_q == ROLL) && last_step) begin
            pasch_o <= (face_a == face_b);
            three_o <= (face_a == 3'd3) || (face_b == 3'd3);
         end
      end
   end

   assign valid_o = (state_q == DONE);
   assign busy_o  = (state_q != IDLE);

endmodule
